mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning the fixed memory read/write latency in cycles; legal range 1..7.
REQ-002 SHALL have parameter STARVE_MAX, default 8, meaning the number of consecutive denied IDLE cycles after which dbg is promoted.
REQ-003 SHALL have ports clk1 in 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port rst in 1, reset; it SHALL be synchronous and active-high.
REQ-005 SHALL have port halt in 1; while high, if_req SHALL be ignored.
REQ-006 SHALL have ports dm_req in 1, dm_we in 1, dm_addr in 32 and dm_wdata in 32, the MEM-stage data request.
REQ-007 SHALL have port dm_gnt out 1, the MEM-stage grant.
REQ-008 SHALL have ports if_req in 1 and if_addr in 32, the fetch read request.
REQ-009 SHALL have port if_gnt out 1, the fetch grant.
REQ-010 SHALL have ports dbg_req in 1, dbg_we in 1, dbg_addr in 32 and dbg_wdata in 32, the debug/loader request.
REQ-011 SHALL have port dbg_gnt out 1, the debug grant.
REQ-012 SHALL have ports dm_rvalid, if_rvalid and dbg_rvalid, each out 1, the per-requester completion pulses.
REQ-013 SHALL have port rdata out 32, the shared read data.
REQ-014 SHALL have port stall_if out 1, the fetch stall to the pipeline.
REQ-015 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out 32 and mem_wdata out 32, the memory command.
REQ-016 SHALL have port mem_rdata in 32, the memory read data.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT and RESP, with one transaction outstanding at most.
REQ-018 In IDLE, SHALL grant one eligible requester combinationally in cycle T: its gnt=1 and mem_en=1, with mem_we/addr/wdata muxed from the winner (mem_we=0 for if).
REQ-019 Priority SHALL be dm > if > dbg; dbg SHALL be highest instead when starve_cnt == STARVE_MAX.
REQ-020 starve_cnt SHALL increment per IDLE cycle with dbg_req=1 and dbg_gnt=0 (saturating), and SHALL clear on dbg grant or dbg_req=0.
REQ-021 After a grant at T, the FSM SHALL be in WAIT for T+1..T+MEM_LAT-1 and in RESP at T+MEM_LAT; with MEM_LAT=1, WAIT SHALL be skipped.
REQ-022 In RESP, the owner's rvalid SHALL be 1 for exactly one cycle and rdata SHALL equal mem_rdata; writes SHALL also pulse rvalid.
REQ-023 rdata SHALL be don't-care outside RESP, and the bench SHALL not check it.
REQ-024 The next grant SHALL be possible no earlier than T+MEM_LAT+1, giving peak throughput of one access per MEM_LAT+1 cycles.
REQ-025 Requesters SHALL hold req/addr/wdata stable until gnt; req deasserted before gnt SHALL be withdrawn without side effect.
REQ-026 stall_if SHALL equal if_req & ~if_gnt & ~halt, combinationally.
REQ-027 halt rising while fetch is owner SHALL let that transaction complete normally.
REQ-028 All gnt signals SHALL be 0 outside IDLE; at most one gnt or rvalid SHALL be high per cycle.
REQ-029 MEM_LAT outside 1..7 SHALL fail elaboration.

Reset
REQ-030 While rst=1: FSM=IDLE, owner=NONE, starve_cnt=0, WAIT counter=0.
REQ-031 While rst=1: all gnt, rvalid and mem_en SHALL be 0; mem_we=0; mem_addr and mem_wdata SHALL be 0.
REQ-032 rst asserted mid-transaction SHALL abort it with no rvalid; the first grant SHALL be possible in the cycle after rst falls.

Structure
REQ-033 Package mips_mem_pkg SHALL hold the owner enum (OWN_NONE, OWN_DM, OWN_IF, OWN_DBG), the FSM state enum, and the default MEM_LAT/STARVE_MAX constants.
REQ-034 The combinational priority picker SHALL be the sub-module mem_arb_prio (inputs: masked reqs, promote flag; output: one-hot winner); the FSM, counters and muxes stay in the top.

Verification (MEM_LAT=2, STARVE_MAX=8)
REQ-035 Single fetch: if_req=1, if_addr=0x0, mem_rdata=0x00011000 at T+2 -> if_gnt at T, if_rvalid at T+2, rdata=0x00011000, stall_if=0 at T.
REQ-036 Contention: dm_req (load 0x40) and if_req in the same cycle -> dm_gnt at T, stall_if=1 for T..T+2, if_gnt at T+3, if_rvalid at T+5.
REQ-037 Starvation: dbg_req held while dm_req/if_req saturate -> dbg_gnt on the first IDLE cycle with starve_cnt=8, after which starve_cnt=0.
REQ-038 Halt: halt=1 with if_req=1 and no other request -> no if_gnt, stall_if=0, mem_en=0 for 10 cycles; a dbg write to 0x4 data 0xDEADBEEF gets dbg_gnt and mem_we=1.
REQ-039 Reset mid-op: rst=1 at T+1 after a dm grant -> no dm_rvalid at T+2, all outputs 0; a new if_req is granted the cycle after rst falls.
REQ-040 MEM_LAT=1 rerun of REQ-035 -> if_rvalid at T+1, next grant at T+2.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and defaults for the memory port arbiter
package mips_mem_pkg;
  localparam int MEM_LAT_DEF = 2;
  localparam int STARVE_MAX_DEF = 8;
  typedef enum logic [1:0] {OWN_NONE, OWN_DM, OWN_IF, OWN_DBG} owner_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  function automatic owner_t win_owner(input logic [2:0] w);
    return w[0] ? OWN_DM : w[1] ? OWN_IF : w[2] ? OWN_DBG : OWN_NONE;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_prio.sv
// mem_arb_prio: one-hot priority pick, dm > if > dbg unless dbg is promoted
module mem_arb_prio (
  input  logic [2:0] req,
  input  logic       promote,
  output logic [2:0] win
);
  always_comb
    win = (promote && req[2]) ? 3'b100 :
          req[0] ? 3'b001 :
          req[1] ? 3'b010 :
          req[2] ? 3'b100 : 3'b000;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-outstanding arbiter of dm/fetch/debug onto one memory port
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        halt,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dm_rvalid,
  output logic        if_rvalid,
  output logic        dbg_rvalid,
  output logic [31:0] rdata,
  output logic        stall_if,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be 1..7");
  end
  state_t state;
  owner_t owner;
  logic [2:0] wcnt;
  logic [SW-1:0] starve;
  logic [2:0] reqs, win, gnt;
  logic idle, resp, promote;
  assign idle = state == S_IDLE && !rst;
  assign resp = state == S_RESP && !rst;
  assign promote = starve == SW'(STARVE_MAX);
  assign reqs = {dbg_req, if_req & ~halt, dm_req};
  mem_arb_prio u_prio (.req(reqs), .promote(promote), .win(win));
  assign gnt = idle ? win : 3'b000;
  assign dm_gnt = gnt[0];
  assign if_gnt = gnt[1];
  assign dbg_gnt = gnt[2];
  assign mem_en = |gnt;
  assign mem_we = gnt[0] ? dm_we : gnt[2] & dbg_we;
  assign mem_addr = gnt[0] ? dm_addr : gnt[1] ? if_addr : gnt[2] ? dbg_addr : 32'h0;
  assign mem_wdata = gnt[0] ? dm_wdata : gnt[2] ? dbg_wdata : 32'h0;
  assign dm_rvalid = resp && owner == OWN_DM;
  assign if_rvalid = resp && owner == OWN_IF;
  assign dbg_rvalid = resp && owner == OWN_DBG;
  assign rdata = mem_rdata;
  assign stall_if = if_req & ~if_gnt & ~halt;
  // starvation counts only denied IDLE cycles; it holds across a busy window
  always_ff @(posedge clk1) begin
    if (rst) begin
      state <= S_IDLE;
      owner <= OWN_NONE;
      wcnt <= '0;
      starve <= '0;
    end else begin
      starve <= (!dbg_req || gnt[2]) ? '0 : (idle && !promote) ? starve + SW'(1) : starve;
      case (state)
        S_IDLE: if (|gnt) begin
          owner <= win_owner(gnt);
          state <= (MEM_LAT == 1) ? S_RESP : S_WAIT;
          wcnt <= (MEM_LAT == 1) ? 3'd0 : 3'd1;
        end
        S_WAIT: if (wcnt == 3'(MEM_LAT - 1)) begin
          state <= S_RESP;
          wcnt <= '0;
        end else wcnt <= wcnt + 3'd1;
        default: begin
          state <= S_IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks against a cycle-count reference model
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  localparam int SMAX = 8;
  logic clk1 = 0;
  always #5 clk1 = ~clk1;
  logic rst, halt, dm_req, dm_we, if_req, dbg_req, dbg_we;
  logic [31:0] dm_addr, dm_wdata, if_addr, dbg_addr, dbg_wdata, mem_rdata;
  logic dm_gnt, if_gnt, dbg_gnt, dm_rvalid, if_rvalid, dbg_rvalid, stall_if, mem_en, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic if_req1, z;
  logic [31:0] if_addr1, z32;
  logic dm_gnt1, if_gnt1, dbg_gnt1, dm_rvalid1, if_rvalid1, dbg_rvalid1, stall_if1, mem_en1, mem_we1;
  logic [31:0] rdata1, mem_addr1, mem_wdata1;
  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk1(clk1), .rst(rst), .halt(halt),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .dm_rvalid(dm_rvalid), .if_rvalid(if_rvalid), .dbg_rvalid(dbg_rvalid), .rdata(rdata),
    .stall_if(stall_if), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
    .clk1(clk1), .rst(rst), .halt(z),
    .dm_req(z), .dm_we(z), .dm_addr(z32), .dm_wdata(z32), .dm_gnt(dm_gnt1),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
    .dbg_req(z), .dbg_we(z), .dbg_addr(z32), .dbg_wdata(z32), .dbg_gnt(dbg_gnt1),
    .dm_rvalid(dm_rvalid1), .if_rvalid(if_rvalid1), .dbg_rvalid(dbg_rvalid1), .rdata(rdata1),
    .stall_if(stall_if1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata));
  int n_cmp = 0, n_err = 0;
  int cyc = 0, free_at = 0, resp_at = -1, starve = 0;
  logic [2:0] rsp_own = 0, g = 0;
  logic s_dm_gnt, s_if_gnt, s_dbg_gnt, s_if_rvalid, s_dm_rvalid, s_stall, s_mem_en, s_mem_we;
  logic s1_if_gnt, s1_if_rvalid;
  logic [31:0] s_rdata, s_addr, s_wdata, s1_rdata;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  // the model tracks when the port frees and when the response is due, in absolute cycles
  task automatic step();
    logic [2:0] w, rv;
    logic idle, rsp, ewe;
    logic [31:0] ea, ed;
    @(negedge clk1);
    w = 0; rv = 0; idle = 0; rsp = 0;
    if (rst) begin
      free_at = cyc + 1; resp_at = -1; starve = 0;
    end else begin
      idle = cyc >= free_at;
      rsp = cyc == resp_at;
      rv = rsp ? rsp_own : 3'b000;
      if (idle) begin
        if (dbg_req && starve == SMAX) w = 3'b100;
        else if (dm_req) w = 3'b001;
        else if (if_req && !halt) w = 3'b010;
        else if (dbg_req) w = 3'b100;
        if (w != 0) begin
          resp_at = cyc + LAT; free_at = cyc + LAT + 1; rsp_own = w;
        end
      end
      if (!dbg_req || w[2]) starve = 0;
      else if (idle && starve < SMAX) starve++;
    end
    ewe = w[0] ? dm_we : (w[2] & dbg_we);
    ea = w[0] ? dm_addr : w[1] ? if_addr : w[2] ? dbg_addr : 32'h0;
    ed = w[0] ? dm_wdata : w[2] ? dbg_wdata : 32'h0;
    chk("ctl", 32'({dm_gnt, if_gnt, dbg_gnt, dm_rvalid, if_rvalid, dbg_rvalid, stall_if, mem_en, mem_we}),
        32'({w[0], w[1], w[2], rv[0], rv[1], rv[2], if_req & ~w[1] & ~halt, |w, ewe}));
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    if (rsp && !rst) chk("rdata", rdata, mem_rdata);
    {s_dm_gnt, s_if_gnt, s_dbg_gnt, s_dm_rvalid, s_if_rvalid} = {dm_gnt, if_gnt, dbg_gnt, dm_rvalid, if_rvalid};
    {s_stall, s_mem_en, s_mem_we, s_rdata, s_addr, s_wdata} = {stall_if, mem_en, mem_we, rdata, mem_addr, mem_wdata};
    {s1_if_gnt, s1_if_rvalid, s1_rdata} = {if_gnt1, if_rvalid1, rdata1};
    g = w;
    cyc++;
    @(posedge clk1);
    #1;
  endtask
  initial begin
    int n;
    logic found;
    z = 0; z32 = 0; if_req1 = 0; if_addr1 = 0;
    rst = 1; halt = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    if_req = 0; if_addr = 0; dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; mem_rdata = 0;
    @(posedge clk1); #1;
    dm_req = 1; if_req = 1; dbg_req = 1;
    repeat (3) step();
    dm_req = 0; if_req = 0; dbg_req = 0; rst = 0;
    step();
    // single fetch
    if_req = 1; if_addr = 32'h0; mem_rdata = 32'h00011000;
    step();
    chk("fetch_gnt", 32'(s_if_gnt), 1);
    chk("fetch_stall", 32'(s_stall), 0);
    if_req = 0;
    step();
    step();
    chk("fetch_rvalid", 32'(s_if_rvalid), 1);
    chk("fetch_rdata", s_rdata, 32'h00011000);
    step();
    // dm beats fetch
    dm_req = 1; dm_we = 0; dm_addr = 32'h40; if_req = 1;
    step();
    chk("cont_dm_gnt", 32'(s_dm_gnt), 1);
    chk("cont_stall0", 32'(s_stall), 1);
    dm_req = 0;
    step();
    chk("cont_stall1", 32'(s_stall), 1);
    step();
    chk("cont_stall2", 32'(s_stall), 1);
    step();
    chk("cont_if_gnt", 32'(s_if_gnt), 1);
    if_req = 0;
    step();
    step();
    chk("cont_if_rvalid", 32'(s_if_rvalid), 1);
    step();
    // starvation promotion
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h100; dm_req = 1; if_req = 1;
    n = 0; found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (s_dbg_gnt) found = 1;
      else if (s_dm_gnt || s_if_gnt) n++;
    end
    chk("starve_found", 32'(found), 1);
    chk("starve_denials", n, SMAX);
    dbg_req = 0; dm_req = 0; if_req = 0;
    repeat (3) step();
    // halt masks fetch
    halt = 1; if_req = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_quiet", 32'({s_if_gnt, s_stall, s_mem_en}), 0);
    end
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h4; dbg_wdata = 32'hDEADBEEF;
    step();
    chk("halt_dbg_gnt", 32'(s_dbg_gnt), 1);
    chk("halt_dbg_we", 32'(s_mem_we), 1);
    chk("halt_dbg_addr", s_addr, 32'h4);
    chk("halt_dbg_wdata", s_wdata, 32'hDEADBEEF);
    dbg_req = 0; if_req = 0; halt = 0;
    repeat (3) step();
    // reset mid-transaction
    dm_req = 1; dm_addr = 32'h80;
    step();
    chk("rst_dm_gnt", 32'(s_dm_gnt), 1);
    dm_req = 0; rst = 1;
    step();
    chk("rst_quiet", 32'({s_dm_gnt, s_if_gnt, s_dbg_gnt, s_dm_rvalid, s_mem_en, s_mem_we}), 0);
    chk("rst_addr", s_addr, 0);
    rst = 0; if_req = 1; if_addr = 32'h200;
    step();
    chk("rst_no_rvalid", 32'(s_dm_rvalid), 0);
    chk("rst_if_gnt", 32'(s_if_gnt), 1);
    if_req = 0;
    repeat (3) step();
    // one-cycle latency instance
    if_req1 = 1; if_addr1 = 32'h0; mem_rdata = 32'h00011000;
    step();
    chk("lat1_gnt", 32'(s1_if_gnt), 1);
    step();
    chk("lat1_rvalid", 32'({s1_if_rvalid, s1_if_gnt}), 32'b10);
    chk("lat1_rdata", s1_rdata, 32'h00011000);
    step();
    chk("lat1_regnt", 32'(s1_if_gnt), 1);
    if_req1 = 0;
    repeat (2) step();
    // random traffic obeying hold-until-grant
    for (int i = 0; i < 500; i++) begin
      if (dm_req) begin
        if (g[0]) dm_req = $urandom_range(1);
        else if ($urandom_range(15) == 0) dm_req = 0;
        if (g[0] && dm_req) begin dm_we = $urandom_range(1); dm_addr = $urandom; dm_wdata = $urandom; end
      end else if ($urandom_range(2) == 0) begin
        dm_req = 1; dm_we = $urandom_range(1); dm_addr = $urandom; dm_wdata = $urandom;
      end
      if (if_req) begin
        if (g[1]) if_req = $urandom_range(1);
        else if ($urandom_range(15) == 0) if_req = 0;
        if (g[1] && if_req) if_addr = $urandom;
      end else if ($urandom_range(2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (dbg_req) begin
        if (g[2]) dbg_req = $urandom_range(1);
        else if ($urandom_range(31) == 0) dbg_req = 0;
        if (g[2] && dbg_req) begin dbg_we = $urandom_range(1); dbg_addr = $urandom; dbg_wdata = $urandom; end
      end else if ($urandom_range(3) == 0) begin
        dbg_req = 1; dbg_we = $urandom_range(1); dbg_addr = $urandom; dbg_wdata = $urandom;
      end
      if ($urandom_range(9) == 0) halt = ~halt;
      rst = $urandom_range(63) == 0;
      mem_rdata = $urandom;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
